// File: rtl/conversor_stdout_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Ports: clk, rst (sync, active-high), dado/inicia in; ocupado, pronto, bcd, negativo out.
module conversor_stdout_bcd #(
  parameter int LARGURA   = 32,
  parameter int DIGITOS   = 10,
  parameter bit COM_SINAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LARGURA-1:0]     dado,
  input  logic                   inicia,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   negativo
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam int BW = 4 * DIGITOS;

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    CONCLUI
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      scr_q, scr_d;
  logic [LARGURA-1:0] mag_q, mag_d;
  logic               neg_tmp_q, neg_tmp_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               pronto_q, pronto_d;
  logic               ocupado_q, ocupado_d;

  logic [BW-1:0]      adj;
  logic               aceita;
  logic [LARGURA-1:0] um;

  assign um = {{(LARGURA-1){1'b0}}, 1'b1};

  // add-3 correction applied to every nibble before the shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = scr_q[4*i +: 4];
    end
  end

  // ocupado_q also covers the cycle after CONCLUI, so a start
  // request coinciding with the pronto pulse is dropped
  assign aceita = (estado_q == OCIOSO) && inicia && !ocupado_q;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    scr_d     = scr_q;
    mag_d     = mag_q;
    neg_tmp_d = neg_tmp_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    pronto_d  = 1'b0;
    ocupado_d = (estado_q != OCIOSO);
    unique case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          if (COM_SINAL && dado[LARGURA-1]) begin
            mag_d     = ~dado + um;
            neg_tmp_d = 1'b1;
          end else begin
            mag_d     = dado;
            neg_tmp_d = 1'b0;
          end
          scr_d     = '0;
          cnt_d     = CW'(LARGURA);
          estado_d  = DESLOCA;
          ocupado_d = 1'b1;
        end
      end
      DESLOCA: begin
        {scr_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          estado_d = CONCLUI;
      end
      CONCLUI: begin
        bcd_d    = scr_q;
        neg_d    = neg_tmp_q;
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      scr_q     <= '0;
      mag_q     <= '0;
      neg_tmp_q <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      scr_q     <= scr_d;
      mag_q     <= mag_d;
      neg_tmp_q <= neg_tmp_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;
  assign bcd      = bcd_q;
  assign negativo = neg_q;

endmodule

// File: tb/tb_conversor_stdout_bcd.sv
// Scoreboard bench for conversor_stdout_bcd.
// Signed and unsigned instances, directed vectors.
module tb_conversor_stdout_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dado, dado_u;
  logic        inicia, inicia_u;
  logic        ocupado, pronto, negativo;
  logic        ocupado_u, pronto_u, negativo_u;
  logic [39:0] bcd, bcd_u;

  int n_cmp = 0;
  int n_bad = 0;

  logic [40:0] q_s[$];
  logic [40:0] q_u[$];
  logic [40:0] e_s, e_u;

  always #5 clk = ~clk;

  conversor_stdout_bcd #(
    .LARGURA(32), .DIGITOS(10), .COM_SINAL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .dado(dado), .inicia(inicia),
    .ocupado(ocupado), .pronto(pronto),
    .bcd(bcd), .negativo(negativo)
  );

  conversor_stdout_bcd #(
    .LARGURA(32), .DIGITOS(10), .COM_SINAL(1'b0)
  ) dut_u (
    .clk(clk), .rst(rst), .dado(dado_u), .inicia(inicia_u),
    .ocupado(ocupado_u), .pronto(pronto_u),
    .bcd(bcd_u), .negativo(negativo_u)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitors: pop and compare on every pronto pulse
  always @(negedge clk) begin
    if (!rst && pronto) begin
      if (q_s.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pronto_s: got bcd %h want none", bcd);
      end else begin
        e_s = q_s.pop_front();
        chk("result_s", {23'd0, negativo, bcd}, {23'd0, e_s});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && pronto_u) begin
      if (q_u.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pronto_u: got bcd %h want none", bcd_u);
      end else begin
        e_u = q_u.pop_front();
        chk("result_u", {23'd0, negativo_u, bcd_u}, {23'd0, e_u});
      end
    end
  end

  // returns at the negedge following the accept edge
  task automatic start(input logic [31:0] v,
                       input logic [40:0] e,
                       input bit push);
    @(negedge clk);
    dado   = v;
    inicia = 1'b1;
    if (push) q_s.push_back(e);
    @(negedge clk);
    inicia = 1'b0;
  endtask

  task automatic wait_pronto(output int lat, output int occ);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    occ  = 0;
    for (int i = 1; i <= 60; i++) begin
      if (!seen) begin
        @(negedge clk);
        if (ocupado) occ++;
        if (pronto) begin
          lat  = i;
          seen = 1'b1;
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_pronto: got none want pulse");
    end
  endtask

  logic [31:0] vin [6];
  logic [40:0] vexp[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, occ;
    vin[0] = 32'd255;        vexp[0] = {1'b0, 40'h00_0000_0255};
    vin[1] = 32'hFFFF_FFFF;  vexp[1] = {1'b1, 40'h00_0000_0001};
    vin[2] = 32'h8000_0000;  vexp[2] = {1'b1, 40'h21_4748_3648};
    vin[3] = 32'h7FFF_FFFF;  vexp[3] = {1'b0, 40'h21_4748_3647};
    vin[4] = 32'hFFFF_FC18;  vexp[4] = {1'b1, 40'h00_0000_1000};
    vin[5] = 32'h3B9A_CA00;  vexp[5] = {1'b0, 40'h10_0000_0000};

    rst = 1'b1; inicia = 1'b0; inicia_u = 1'b0;
    dado = '0; dado_u = '0;
    repeat (3) @(negedge clk);
    chk("rst_ocupado",  ocupado,  0);
    chk("rst_pronto",   pronto,   0);
    chk("rst_bcd",      bcd,      0);
    chk("rst_negativo", negativo, 0);
    rst = 1'b0;

    // zero, with latency and busy window
    start(32'd0, {1'b0, 40'h0}, 1'b1);
    wait_pronto(lat, occ);
    chk("lat_zero", lat, 33);
    chk("ocupado_cycles", occ, 33);
    @(negedge clk);
    chk("ocupado_fall", ocupado, 0);

    for (int k = 0; k < 6; k++) begin
      start(vin[k], vexp[k], 1'b1);
      wait_pronto(lat, occ);
      chk("lat_vec", lat, 33);
    end

    // unsigned instance
    @(negedge clk);
    dado_u = 32'hFFFF_FFFF;
    inicia_u = 1'b1;
    q_u.push_back({1'b0, 40'h42_9496_7295});
    @(negedge clk);
    inicia_u = 1'b0;
    repeat (40) @(negedge clk);
    chk("u_drained", q_u.size(), 0);

    // starts during a conversion and in the pronto cycle are dropped
    start(32'd12345, {1'b0, 40'h00_0001_2345}, 1'b1);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (i == 9 || i == 33) begin
        dado = 32'd99;
        inicia = 1'b1;
      end
      if (i == 10 || i == 34) inicia = 1'b0;
      if (i == 32) chk("bcd_hold", bcd, 40'h10_0000_0000);
      if (i == 33) chk("ovl_pronto", pronto, 1);
    end
    repeat (50) @(negedge clk);
    chk("ovl_idle", ocupado, 0);
    chk("ovl_bcd_kept", bcd, 40'h00_0001_2345);

    // reset mid-conversion aborts
    start(32'd777, '0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 14) rst = 1'b1;
      if (i == 15) begin
        rst = 1'b0;
        chk("abort_bcd",      bcd,      0);
        chk("abort_ocupado",  ocupado,  0);
        chk("abort_negativo", negativo, 0);
      end
    end
    repeat (50) @(negedge clk);
    chk("abort_no_pronto_idle", ocupado, 0);

    start(32'd42, {1'b0, 40'h00_0000_0042}, 1'b1);
    wait_pronto(lat, occ);
    chk("lat_after_abort", lat, 33);

    @(negedge clk);
    chk("s_drained", q_s.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
